// File: rtl/stepper_speed_ctrl_if.sv
// Button/mode inputs and speed-status outputs of stepper_speed_ctrl.
// The controller takes the slave modport; the driving side takes the master modport.
interface stepper_speed_ctrl_if #(
    parameter int LEVEL_W = 3
);
    logic               speed_button;
    logic [1:0]         mode;
    logic [LEVEL_W-1:0] target_level;
    logic [LEVEL_W-1:0] out_speed;
    logic               dir_up;
    logic               ramp_busy;
    logic               at_limit;

    modport master (
        output speed_button, mode,
        input  target_level, out_speed, dir_up, ramp_busy, at_limit
    );

    modport slave (
        input  speed_button, mode,
        output target_level, out_speed, dir_up, ramp_busy, at_limit
    );
endinterface

// File: rtl/stepper_speed_ctrl.sv
// Push-button stepper speed selector with a rate-limited ramp toward the requested level.
// Define STEPPER_DEBOUNCE_EN to add a DB_CYCLES stable-count filter on the synchronized button.
module stepper_speed_ctrl #(
    parameter int LEVEL_W   = 3,
    parameter int MIN_LEVEL = 1,
    parameter int MAX_LEVEL = 6,
    parameter int RAMP_DIV  = 1000,
    parameter int DB_CYCLES = 16
) (
    input logic                 clk,
    input logic                 resetb,
    stepper_speed_ctrl_if.slave bus
);

    localparam logic [LEVEL_W-1:0] MIN_L = LEVEL_W'(MIN_LEVEL);
    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] ONE   = LEVEL_W'(1);
    localparam int                 DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);

    if (MIN_LEVEL >= MAX_LEVEL || MAX_LEVEL >= (1 << LEVEL_W) || RAMP_DIV < 1 || DB_CYCLES < 1) begin : g_bad_params
        $error("stepper_speed_ctrl: invalid parameter set");
    end

    typedef enum logic {
        IDLE,
        RAMP
    } ramp_state_t;

    logic btn_meta, btn_sync;
    logic sync_vld1, sync_vld2;
    logic armed;
    logic filt, filt_d;
    logic press;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            btn_meta  <= 1'b1;
            btn_sync  <= 1'b1;
            sync_vld1 <= 1'b0;
            sync_vld2 <= 1'b0;
        end else begin
            btn_meta  <= bus.speed_button;
            btn_sync  <= btn_meta;
            sync_vld1 <= 1'b1;
            sync_vld2 <= sync_vld1;
        end
    end

`ifdef STEPPER_DEBOUNCE_EN
    localparam int             DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            filt   <= 1'b1;
            db_cnt <= '0;
        end else if (btn_sync == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            filt   <= btn_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_ONE;
        end
    end
`else
    assign filt = btn_sync;
`endif

    // Reset forces the chain to "released"; events are only armed once a genuine
    // released sample has come through, so a button held across reset stays silent.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            armed  <= 1'b0;
            filt_d <= 1'b1;
        end else begin
            filt_d <= filt;
            if (sync_vld2 && btn_sync)
                armed <= 1'b1;
        end
    end

    assign press = armed & filt_d & ~filt;

    logic [LEVEL_W-1:0] target, tgt_inc, tgt_dec;
    logic               dir;

    assign tgt_inc = target + ONE;
    assign tgt_dec = target - ONE;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            target <= MIN_L;
            dir    <= 1'b1;
        end else if (press) begin
            case (bus.mode)
                2'b00: begin
                    if (target == MAX_L) begin
                        target <= tgt_dec;
                        dir    <= 1'b0;
                    end else if (target == MIN_L) begin
                        target <= tgt_inc;
                        dir    <= 1'b1;
                    end else if (dir) begin
                        target <= tgt_inc;
                        if (tgt_inc == MAX_L)
                            dir <= 1'b0;
                    end else begin
                        target <= tgt_dec;
                        if (tgt_dec == MIN_L)
                            dir <= 1'b1;
                    end
                end
                2'b01: if (target != MAX_L) target <= tgt_inc;
                2'b10: if (target != MIN_L) target <= tgt_dec;
                default: ;
            endcase
        end
    end

    ramp_state_t        state;
    logic [DIV_W-1:0]   div;
    logic [LEVEL_W-1:0] out_lvl, out_toward;
    logic               step_due;

    assign step_due   = (div == DIV_LAST);
    assign out_toward = (target > out_lvl) ? out_lvl + ONE : out_lvl - ONE;

    // The divider also counts the IDLE->RAMP cycle so the first step lands
    // RAMP_DIV clocks after the target change; retargeting never restarts it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            div     <= '0;
            out_lvl <= MIN_L;
        end else begin
            case (state)
                IDLE: begin
                    if (out_lvl != target) begin
                        state <= RAMP;
                        if (step_due) begin
                            out_lvl <= out_toward;
                            div     <= '0;
                        end else begin
                            div <= div + DIV_ONE;
                        end
                    end else begin
                        div <= '0;
                    end
                end
                RAMP: begin
                    if (out_lvl == target) begin
                        state <= IDLE;
                        div   <= '0;
                    end else if (step_due) begin
                        out_lvl <= out_toward;
                        div     <= '0;
                    end else begin
                        div <= div + DIV_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.target_level = target;
    assign bus.out_speed    = out_lvl;
    assign bus.dir_up       = dir;
    assign bus.ramp_busy    = (out_lvl != target);
    assign bus.at_limit     = (target == MIN_L) || (target == MAX_L);

endmodule

// File: tb/tb_stepper_speed_ctrl.sv
// Self-checking bench for stepper_speed_ctrl: directed scenarios plus randomized
// presses scored against a level/direction model built from the press rules.
module tb_stepper_speed_ctrl;

    localparam int LEVEL_W  = 3;
    localparam int MIN_LV   = 1;
    localparam int MAX_LV   = 6;
    localparam int RAMP_DIV = 4;
    localparam int LOG_LEN  = 30;
`ifdef STEPPER_DEBOUNCE_EN
    localparam int HOLD    = 8;
    localparam int RST_TGT = 5;
`else
    localparam int HOLD    = 3;
    localparam int RST_TGT = 6;
`endif
    localparam int SETTLE = RAMP_DIV * (MAX_LV - MIN_LV) + 8;

    logic clk = 1'b0;
    logic resetb = 1'b0;

    stepper_speed_ctrl_if #(.LEVEL_W(LEVEL_W)) bus ();

    stepper_speed_ctrl #(
        .LEVEL_W  (LEVEL_W),
        .MIN_LEVEL(MIN_LV),
        .MAX_LEVEL(MAX_LV),
        .RAMP_DIV (RAMP_DIV),
        .DB_CYCLES(3)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int m_target = MIN_LV;
    int m_dir    = 1;
    int pp_seq[10] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    int log_t[LOG_LEN];
    int log_o[LOG_LEN];
    int log_b[LOG_LEN];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_press(input int md);
        case (md)
            0: begin
                if (m_target == MAX_LV) begin
                    m_target--; m_dir = 0;
                end else if (m_target == MIN_LV) begin
                    m_target++; m_dir = 1;
                end else if (m_dir == 1) begin
                    m_target++;
                    if (m_target == MAX_LV) m_dir = 0;
                end else begin
                    m_target--;
                    if (m_target == MIN_LV) m_dir = 1;
                end
            end
            1: if (m_target < MAX_LV) m_target++;
            2: if (m_target > MIN_LV) m_target--;
            default: ;
        endcase
    endtask

    task automatic press(input int md, input int low, input int high);
        bus.mode = md[1:0];
        bus.speed_button = 1'b0;
        step(low);
        bus.speed_button = 1'b1;
        step(high);
        model_press(md);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_target"}, int'(bus.target_level), m_target);
        check_eq({tag, "_dir"}, int'(bus.dir_up), m_dir);
        check_eq({tag, "_limit"}, int'(bus.at_limit), int'(m_target == MIN_LV || m_target == MAX_LV));
    endtask

    task automatic settle_check(input string tag);
        step(SETTLE);
        check_eq({tag, "_out"}, int'(bus.out_speed), m_target);
        check_eq({tag, "_busy"}, int'(bus.ramp_busy), 0);
    endtask

    function automatic logic ramp_btn(input int i);
`ifdef STEPPER_DEBOUNCE_EN
        return (i >= 6);
`else
        return !(i < 2 || i == 3 || i == 4);
`endif
    endfunction

    function automatic logic rst_btn(input int i);
`ifdef STEPPER_DEBOUNCE_EN
        return (i < 0);
`else
        return (i == 2);
`endif
    endfunction

    task automatic reset_checks(input string tag);
        check_eq({tag, "_target"}, int'(bus.target_level), MIN_LV);
        check_eq({tag, "_out"}, int'(bus.out_speed), MIN_LV);
        check_eq({tag, "_dir"}, int'(bus.dir_up), 1);
        check_eq({tag, "_busy"}, int'(bus.ramp_busy), 0);
        check_eq({tag, "_limit"}, int'(bus.at_limit), 1);
    endtask

    initial begin
        int t1;
        int saved_t, saved_d;
        bit found;

        bus.speed_button = 1'b1;
        bus.mode = 2'b00;
        resetb = 1'b0;
        step(3);
        reset_checks("rst");
        resetb = 1'b1;
        step(5);

        // ping-pong sweep from reset
        for (int i = 0; i < 10; i++) begin
            press(0, HOLD, HOLD);
            check_state("pp");
            check_eq("pp_seq", int'(bus.target_level), pp_seq[i]);
            if (i == 4) check_eq("pp_dir_p5", int'(bus.dir_up), 0);
            if (i == 9) check_eq("pp_dir_p10", int'(bus.dir_up), 1);
        end
        settle_check("pp_settle");

        // saturation both ways
        for (int i = 0; i < 7; i++) press(1, HOLD, HOLD);
        check_state("up_sat");
        check_eq("up_sat_max", int'(bus.target_level), MAX_LV);
        for (int i = 0; i < 7; i++) press(2, HOLD, HOLD);
        check_state("dn_sat");
        check_eq("dn_sat_min", int'(bus.target_level), MIN_LV);
        settle_check("sat_settle");

        // ramp timing from a settled level 1
        bus.mode = 2'b01;
        for (int i = 0; i < LOG_LEN; i++) begin
            bus.speed_button = ramp_btn(i);
            step(1);
            log_t[i] = int'(bus.target_level);
            log_o[i] = int'(bus.out_speed);
            log_b[i] = int'(bus.ramp_busy);
        end
        bus.speed_button = 1'b1;
        model_press(1);
`ifndef STEPPER_DEBOUNCE_EN
        model_press(1);
`endif
        found = 1'b0;
        t1 = 0;
        for (int i = 0; i < LOG_LEN; i++)
            if (!found && log_t[i] != MIN_LV) begin
                found = 1'b1;
                t1 = i;
            end
        check_eq("ramp_start_found", int'(found), 1);
        if (found && t1 + 8 < LOG_LEN) begin
            check_eq("ramp_out_t3", log_o[t1+3], 1);
            check_eq("ramp_out_t4", log_o[t1+4], 2);
            check_eq("ramp_busy_t3", log_b[t1+3], 1);
`ifdef STEPPER_DEBOUNCE_EN
            check_eq("ramp_busy_t4", log_b[t1+4], 0);
`else
            check_eq("ramp_out_t7", log_o[t1+7], 2);
            check_eq("ramp_out_t8", log_o[t1+8], 3);
            check_eq("ramp_busy_t7", log_b[t1+7], 1);
            check_eq("ramp_busy_t8", log_b[t1+8], 0);
`endif
        end else begin
            check_eq("ramp_window", t1, 0);
        end
        check_eq("ramp_final_target", log_t[LOG_LEN-1], m_target);
        settle_check("ramp_settle");

        // hold mode ignores presses
        saved_t = m_target;
        saved_d = m_dir;
        for (int i = 0; i < 5; i++) press(3, HOLD, HOLD);
        check_eq("hold_target", int'(bus.target_level), saved_t);
        check_eq("hold_dir", int'(bus.dir_up), saved_d);
        check_eq("hold_out", int'(bus.out_speed), saved_t);

`ifdef STEPPER_DEBOUNCE_EN
        bus.mode = 2'b01;
        bus.speed_button = 1'b0;
        step(2);
        bus.speed_button = 1'b1;
        step(10);
        check_state("glitch2");
        press(1, 5, 10);
        check_state("low5");
`endif

        // long hold yields exactly one event
        press(1, 100, HOLD);
        check_state("held100");
        settle_check("held_settle");

        // randomized presses, short gaps leave ramps in flight
        for (int it = 0; it < 60; it++) begin
            int md;
            md = int'($urandom_range(0, 3));
            press(md, HOLD + int'($urandom_range(0, 3)), HOLD + int'($urandom_range(0, 4)));
            check_state("rnd");
            if (it % 8 == 7) settle_check("rnd_settle");
        end
        settle_check("rnd_final");

        // reset mid-ramp with the button held
        for (int i = 0; i < 7; i++) press(1, HOLD, HOLD);
        press(2, HOLD, HOLD);
        press(2, HOLD, HOLD);
        settle_check("pre_rst");
        check_eq("pre_rst_level", int'(bus.out_speed), 4);
        bus.mode = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            bus.speed_button = rst_btn(i);
            step(1);
            if (int'(bus.target_level) == RST_TGT) found = 1'b1;
        end
        check_eq("rst_mid_found", int'(found), 1);
        check_eq("rst_mid_out", int'(bus.out_speed), 4);
        check_eq("rst_mid_busy", int'(bus.ramp_busy), 1);
        #2;
        resetb = 1'b0;
        #1;
        reset_checks("rst_async");
        step(3);
        resetb = 1'b1;
        step(30);
        reset_checks("rst_held_btn");
        m_target = MIN_LV;
        m_dir = 1;
        bus.speed_button = 1'b1;
        step(HOLD);
        check_state("rst_release");
        press(1, HOLD, HOLD);
        check_state("rst_fresh_press");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stepper_speed_ctrl.md
STEPPER_SPEED_CTRL -- requirements
Module: stepper_speed_ctrl

Interface
REQ-001 SHALL provide parameter LEVEL_W, default 3, width of speed-level values.
REQ-002 SHALL provide parameter MIN_LEVEL, default 1, lowest speed level (10 laps/min).
REQ-003 SHALL provide parameter MAX_LEVEL, default 6, highest speed level (60 laps/min); MIN_LEVEL < MAX_LEVEL < 2**LEVEL_W.
REQ-004 SHALL provide parameter RAMP_DIV, default 1000, clk cycles per one-level ramp step (>=1).
REQ-005 SHALL provide parameter DB_CYCLES, default 16, debounce stable-count length (>=1).
REQ-006 clk  input  1  system clock, all state rising-edge.
REQ-007 resetb  input  1  reset, asynchronous, active-low.
REQ-008 speed_button  input  1  raw asynchronous push button, active-low (pressed = 0).
REQ-009 mode  input  2  00 ping-pong, 01 up-saturate, 10 down-saturate, 11 hold.
REQ-010 target_level  output  LEVEL_W  requested speed level.
REQ-011 out_speed  output  LEVEL_W  applied (ramped) speed level.
REQ-012 dir_up  output  1  ping-pong direction, 1 = increasing.
REQ-013 ramp_busy  output  1  high while out_speed != target_level.
REQ-014 at_limit  output  1  high when target_level == MIN_LEVEL or MAX_LEVEL.

Function
REQ-015 speed_button SHALL pass a 2-flop synchronizer before any use.
REQ-016 Press event SHALL be a single-cycle pulse on the 1->0 transition of the filtered button; holding the button SHALL yield exactly one event.
REQ-017 Mode 00: target==MAX -> target-1, dir_up=0; target==MIN -> target+1, dir_up=1; otherwise target+-1 per dir_up, dir_up flips in the same cycle the new target lands on MAX or MIN.
REQ-018 Mode 01: press increments target, saturating at MAX_LEVEL; dir_up unchanged.
REQ-019 Mode 10: press decrements target, saturating at MIN_LEVEL; dir_up unchanged.
REQ-020 Mode 11: presses ignored; target and dir_up hold.
REQ-021 target_level SHALL update one clk after the press pulse; arithmetic never wraps.
REQ-022 Ramp FSM states IDLE, RAMP: IDLE->RAMP when out_speed != target; RAMP->IDLE when equal.
REQ-023 In RAMP a divider counts RAMP_DIV cycles, then out_speed moves one level toward target and the divider restarts; first step occurs RAMP_DIV cycles after target change.
REQ-024 Target change during RAMP SHALL not restart the divider; ramp continues toward the new target, reversing direction if needed.
REQ-025 Divider SHALL clear on entry to IDLE.
REQ-026 ramp_busy and at_limit SHALL be combinational from registered state.
REQ-027 Mode change SHALL take effect on the next press; no effect on ramp.

Reset
REQ-028 resetb low SHALL asynchronously set target_level=MIN_LEVEL, out_speed=MIN_LEVEL, dir_up=1, FSM=IDLE, divider=0, synchronizer/filter to released (1).
REQ-029 Reset mid-ramp or mid-press SHALL discard pending events; after release no press event until a fresh 1->0 transition.
REQ-030 After reset ramp_busy=0, at_limit=1.

Configuration
REQ-031 Macro STEPPER_DEBOUNCE_EN defined: filtered button changes only after synchronized input holds a new value for DB_CYCLES consecutive clks.
REQ-032 Macro STEPPER_DEBOUNCE_EN undefined: filtered button = synchronized button; DB_CYCLES unused; no debounce logic synthesised.

Verification (bench: RAMP_DIV=4, DB_CYCLES=3, defaults otherwise)
REQ-033 Mode 00, 10 clean presses from reset -> target 2,3,4,5,6,5,4,3,2,1; dir_up 0 at press 5, 1 at press 10.
REQ-034 Mode 01, 7 presses -> target saturates at 6, at_limit=1; mode 10, 7 presses -> saturates at 1.
REQ-035 Target 1->3 in one cycle window -> out_speed 2 after 4 clks, 3 after 8 clks, ramp_busy falls same cycle as equality.
REQ-036 With STEPPER_DEBOUNCE_EN: 2-cycle glitch low -> no event; 5-cycle low -> exactly one event; held low 100 cycles -> one event.
REQ-037 resetb low mid-ramp (out_speed=4, target=6) -> all outputs at reset values immediately, no event after release while button held.
REQ-038 Mode 11, 5 presses -> target, dir_up, out_speed unchanged.
